// File: rtl/fc_argmax_classifier_if.sv
// Score-stream / result handshake bundle for fc_argmax_classifier.
// The out_margin field exists only when CLS_MARGIN_EN is defined.
`timescale 1ns/1ps
interface fc_argmax_classifier_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [IDX_W-1:0]         out_class;
  logic signed [DATA_W-1:0] out_score;
  logic                     out_err;
`ifdef CLS_MARGIN_EN
  logic [DATA_W:0]          out_margin;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_class, out_score, out_err, out_margin
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_class, out_score, out_err, out_margin
  );
`else
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_class, out_score, out_err
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_class, out_score, out_err
  );
`endif
endinterface

// File: rtl/fc_argmax_classifier.sv
// Streaming argmax over one frame of class scores with length checking.
// Define CLS_MARGIN_EN to also track the runner-up and report out_margin.
`timescale 1ns/1ps
module fc_argmax_classifier #(
  parameter int DATA_W      = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fc_argmax_classifier_if.slave  bus
);
  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(NUM_CLASSES - 1);

  state_t                   state_reg, state_next;
  logic [IDX_W:0]           cnt_reg, cnt_next;
  logic signed [DATA_W-1:0] best_reg, best_next;
  logic [IDX_W-1:0]         best_idx_reg, best_idx_next;
  logic [IDX_W-1:0]         out_class_reg;
  logic signed [DATA_W-1:0] out_score_reg;
  logic                     out_err_reg;

  logic signed [DATA_W-1:0] data;
  logic                     accept;
  logic                     first;
  logic                     at_end;
  logic                     terminate;

  assign data      = bus.in_data;
  assign accept    = bus.in_valid && (state_reg == ACCUM);
  assign first     = (cnt_reg == '0);
  assign at_end    = (cnt_reg == LAST_CNT);
  assign terminate = accept && (bus.in_last || at_end);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    best_next     = best_reg;
    best_idx_next = best_idx_reg;
    case (state_reg)
      ACCUM: begin
        if (accept) begin
          cnt_next = cnt_reg + 1'b1;
          // Strict compare keeps the earliest index on ties.
          if (first || (data > best_reg)) begin
            best_next     = data;
            best_idx_next = cnt_reg[IDX_W-1:0];
          end
          if (terminate) begin
            state_next = HOLD;
            cnt_next   = '0;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_next = ACCUM;
          cnt_next   = '0;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ACCUM;
      cnt_reg       <= '0;
      best_reg      <= '0;
      best_idx_reg  <= '0;
      out_class_reg <= '0;
      out_score_reg <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      best_reg     <= best_next;
      best_idx_reg <= best_idx_next;
      if (terminate) begin
        out_class_reg <= best_idx_next;
        out_score_reg <= best_next;
        // Either in_last before the full count, or full count without in_last.
        out_err_reg   <= bus.in_last ^ at_end;
      end
    end
  end

`ifdef CLS_MARGIN_EN
  localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] second_reg, second_next;
  logic signed [DATA_W:0]   margin_next;
  logic [DATA_W:0]          out_margin_reg;

  always_comb begin
    second_next = second_reg;
    if (accept) begin
      if (first)
        second_next = SCORE_MIN;
      else if (data > best_reg)
        second_next = best_reg;
      else if (data > second_reg)
        second_next = data;
    end
  end

  // Extra bit so best minus runner-up cannot overflow.
  assign margin_next = {best_next[DATA_W-1], best_next} - {second_next[DATA_W-1], second_next};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_reg     <= SCORE_MIN;
      out_margin_reg <= '0;
    end else begin
      second_reg <= second_next;
      if (terminate)
        out_margin_reg <= margin_next;
    end
  end

  assign bus.out_margin = out_margin_reg;
`endif

  assign bus.in_ready  = (state_reg == ACCUM);
  assign bus.out_valid = (state_reg == HOLD);
  assign bus.out_class = out_class_reg;
  assign bus.out_score = out_score_reg;
  assign bus.out_err   = out_err_reg;
endmodule
